// File: rtl/timer_regs_pkg.sv
// Register map, control-word encodings and master FSM states for the interval timer.
// Shared by every master and slave that talks to this timer.
package timer_regs_pkg;

    localparam int REG_STATUS  = 0;
    localparam int REG_CONTROL = 1;
    localparam int REG_PERIODL = 2;
    localparam int REG_PERIODH = 3;
    localparam int REG_SNAPL   = 4;
    localparam int REG_SNAPH   = 5;

    localparam int CTRL_IE    = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_START_WORD =
        16'((1 << CTRL_IE) | (1 << CTRL_CONT) | (1 << CTRL_START));
    localparam logic [15:0] CTRL_STOP_WORD  = 16'(1 << CTRL_STOP);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_IRQ,
        ST_CLR,
        ST_SNAP,
        ST_RD_L,
        ST_RD_H,
        ST_DONE,
        ST_STOP
    } state_t;

endpackage

// File: rtl/timer_service_master.sv
// Avalon-MM master that starts the interval timer, services each timeout and
// exports a tick pulse, a wrapping tick count and the snapshot taken at service time.
module timer_service_master
    import timer_regs_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter int SNAP_W = 19,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              irq,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic              tick,
    output logic [CNT_W-1:0]  tick_count,
    output logic [SNAP_W-1:0] snap_value,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              cs_nxt;
    logic              wn_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wd_nxt;
    logic [DATA_W-1:0] snap_lo;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cs_nxt    = 1'b0;
        wn_nxt    = 1'b1;
        addr_nxt  = '0;
        wd_nxt    = '0;

        case (state)
            ST_IDLE:     if (run) state_nxt = ST_INIT;
            ST_INIT:     state_nxt = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                if (irq)       state_nxt = ST_CLR;
                else if (!run) state_nxt = ST_STOP;
            end
            ST_CLR:      state_nxt = ST_SNAP;
            ST_SNAP:     state_nxt = ST_RD_L;
            ST_RD_L:     state_nxt = ST_RD_H;
            ST_RD_H:     state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_WAIT_IRQ;
            ST_STOP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase

        // Bus signals are decoded from the state being entered so that the
        // registered outputs line up with that state's cycle.
        case (state_nxt)
            ST_INIT: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_W'(REG_CONTROL);
                wd_nxt   = DATA_W'(CTRL_START_WORD);
            end
            ST_CLR: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_W'(REG_STATUS);
            end
            ST_SNAP: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_W'(REG_SNAPL);
            end
            ST_RD_L: begin
                cs_nxt   = 1'b1;
                addr_nxt = ADDR_W'(REG_SNAPL);
            end
            ST_RD_H: begin
                cs_nxt   = 1'b1;
                addr_nxt = ADDR_W'(REG_SNAPH);
            end
            ST_STOP: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_W'(REG_CONTROL);
                wd_nxt   = DATA_W'(CTRL_STOP_WORD);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
            snap_value <= '0;
            snap_lo    <= '0;
        end else begin
            state      <= state_nxt;
            chipselect <= cs_nxt;
            write_n    <= wn_nxt;
            address    <= addr_nxt;
            writedata  <= wd_nxt;
            tick       <= 1'b0;

            if (state == ST_IDLE && run)
                tick_count <= '0;

            // Slave read data arrives one cycle after the address cycle.
            if (state == ST_RD_H)
                snap_lo <= readdata;

            if (state == ST_DONE) begin
                snap_value <= SNAP_W'({readdata, snap_lo});
                tick_count <= tick_count + CNT_W'(1);
                tick       <= 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/timer_service_master.md
# timer_service_master

Avalon-MM master that owns one interval-timer peripheral on the configuration bus: it programs the timer's control register, services every timeout interrupt, and exports a tick pulse, a running tick count and the timer's snapshot value captured at service time. It sits between the timer slave (16-bit data, 3-bit word address, no waitrequest, registered readdata) and fabric logic that needs a periodic time base without a CPU.

## Interface
- `ADDR_W`, 3: slave word-address width.
- `DATA_W`, 16: bus data width.
- `SNAP_W`, 19: meaningful snapshot bits; upper bits of the 32-bit read are discarded.
- `CNT_W`, 32: tick counter width.

- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `run`  in  1: level; high means keep the timer running and serviced.
- `irq`  in  1: timer interrupt, level.
- `address`  out  ADDR_W: slave word address.
- `chipselect`  out  1: access strobe, one cycle per access.
- `write_n`  out  1: low means write, valid with chipselect.
- `writedata`  out  DATA_W: write data.
- `readdata`  in  DATA_W: registered slave read data.
- `tick`  out  1: one-cycle pulse per serviced timeout.
- `tick_count`  out  CNT_W: serviced timeouts since start; wraps.
- `snap_value`  out  SNAP_W: counter snapshot from the latest service.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Register map used: 0 status (write clears timeout), 1 control (bit0 IE, bit1 CONT, bit2 START, bit3 STOP), 4/5 snapshot low/high (write triggers snapshot; read returns halves).
- States: IDLE, INIT, WAIT_IRQ, CLR, SNAP, RD_L, RD_H, DONE, STOP.
- IDLE: bus idle; `run`=1 → INIT. INIT clears `tick_count` to 0.
- INIT: write addr 1, data 0x0007 → WAIT_IRQ.
- WAIT_IRQ: `irq`=1 → CLR (irq takes priority over `run`=0); else `run`=0 → STOP.
- CLR: write addr 0, data 0 → SNAP. SNAP: write addr 4, data 0 → RD_L.
- RD_L: read addr 4 → RD_H. RD_H: capture `readdata` as low half; read addr 5 → DONE.
- DONE: capture `readdata` as high half; bus idle; set `snap_value` to the {high, low} combination truncated to SNAP_W; increment `tick_count` modulo 2^CNT_W; assert `tick` next cycle → WAIT_IRQ.
- STOP: write addr 1, data 0x0008 (stop, IE off) → IDLE.
- `run` falling mid-service does not abort; the sequence completes, then WAIT_IRQ → STOP.
- Bus idle means: `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0. All bus outputs are registered.

## Timing
- Reset values: `chipselect` 0, `write_n` 1, `address` 0, `writedata` 0, `tick` 0, `tick_count` 0, `snap_value` 0, `busy` 0, state IDLE. Assertion mid-access drops `chipselect` immediately (asynchronous).
- Each write occupies exactly one cycle with `chipselect`=1; no back-pressure.
- Read latency is fixed at 1: `readdata` is sampled in the cycle after the address cycle.
- irq sampled high on edge E0 → CLR, SNAP, RD_L, RD_H and DONE drive during the cycles following E0, E1, E2, E3 and E4 → `tick`=1 in the cycle following E5, together with the updated `tick_count` and `snap_value`.
- The slave clears `irq` in the cycle after CLR, so no timeout is serviced twice; timeouts during a service are merged by the slave.
- `run` rising → INIT write drives in the following cycle. Back-to-back services are limited to one per 6 cycles.

## Structure
- Shared package `timer_regs_pkg`: register address constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5), control bit indices, START/STOP control words, state enum.
- Single module; no sub-module. Package reused by future timer masters and slaves.

## Test plan
- Reset, then `run`=1 → next cycle write addr 1 data 0x0007; `busy`=1; `tick_count`=0.
- Slave model raises irq; it clears on a status write; snapshot reads return 0x2345 then 0x0006 → writes to addr 0 and addr 4, reads of 4 and 5, `tick` pulses 6 cycles after irq, `snap_value`=0x62345, `tick_count`=1.
- 3 irqs 100 cycles apart → exactly 3 `tick` pulses, `tick_count`=3, no duplicate status writes.
- `run`=0 during RD_L → service completes (`tick_count` increments), then write addr 1 data 0x0008, IDLE, `busy`=0.
- `tick_count` preset near 2^CNT_W−1 (CNT_W=4, 15 services then one more) → wraps to 0 with `tick` asserted.
- `reset` asserted while `chipselect`=1 in SNAP → all outputs return to reset values asynchronously; after release and `run`=1, the INIT write is repeated.
